// File: rtl/jt51_wr_seq.sv
`default_nettype none
// ============================================================================
// Module   : jt51_wr_seq
// Brief    : Queued YM2151 register-write sequencer (address strobe, gap,
//            data strobe, busy wait). Optional JT51_WRSEQ_ADDRSKIP_EN skips
//            the address phase when the chip already holds that address.
// Revision : 1.0  initial release
// ============================================================================
module jt51_wr_seq #(
  parameter int AW  = 2,
  parameter int PW  = 2,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [7:0]    req_addr,
  input  logic [7:0]    req_data,
  output logic          req_ready,
  output logic [AW:0]   pending,
  output logic [7:0]    dout,
  output logic          a0,
  output logic          write,
  input  logic          busy,
  output logic          done,
  output logic          idle
);

  localparam int          C_DEPTH    = 1 << AW;
  localparam logic [AW:0] C_FULL     = (AW+1)'(C_DEPTH);
  localparam logic [3:0]  C_PW_LOAD  = 4'(PW - 1);
  localparam logic [3:0]  C_GAP_LOAD = 4'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADR   = 3'd1,
    S_AGAP  = 3'd2,
    S_DAT   = 3'd3,
    S_BWAIT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   mem_q [C_DEPTH];
  logic [15:0]   mem_d [C_DEPTH];
  logic [7:0]    work_data_q, work_data_d;
  logic [7:0]    dout_q, dout_d;
  logic          a0_q, a0_d;
`ifdef JT51_WRSEQ_ADDRSKIP_EN
  logic [7:0]    last_addr_q, last_addr_d;
  logic          last_vld_q, last_vld_d;
`endif

  logic        full;
  logic        push;
  logic        pop;
  logic [15:0] head;

  assign full      = (count_q == C_FULL);
  assign req_ready = ~full;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign push      = req_valid && (!full || pop);
  assign head      = mem_q[rd_ptr_q];

  assign pending = count_q;
  assign dout    = dout_q;
  assign a0      = a0_q;
  assign write   = (state_q == S_ADR) || (state_q == S_DAT);
  assign idle    = (state_q == S_IDLE) && (count_q == '0);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_data_d = work_data_q;
    dout_d      = dout_q;
    a0_d        = a0_q;
    done        = 1'b0;
`ifdef JT51_WRSEQ_ADDRSKIP_EN
    last_addr_d = last_addr_q;
    last_vld_d  = last_vld_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = {req_addr, req_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end

    // The phase counter reloads on every state entry and only counts down to zero.
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          work_data_d = head[7:0];
          state_d     = S_ADR;
          cnt_d       = C_PW_LOAD;
          dout_d      = head[15:8];
          a0_d        = 1'b0;
`ifdef JT51_WRSEQ_ADDRSKIP_EN
          last_addr_d = head[15:8];
          last_vld_d  = 1'b1;
          if (last_vld_q && (head[15:8] == last_addr_q)) begin
            state_d = S_DAT;
            dout_d  = head[7:0];
            a0_d    = 1'b1;
          end
`endif
        end
      end
      S_ADR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_AGAP;
          cnt_d   = C_GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_AGAP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DAT;
          cnt_d   = C_PW_LOAD;
          dout_d  = work_data_q;
          a0_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DAT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_BWAIT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_BWAIT: begin
        if (!busy) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      work_data_q <= 8'd0;
      dout_q      <= 8'd0;
      a0_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      work_data_q <= work_data_d;
      dout_q      <= dout_d;
      a0_q        <= a0_d;
    end
  end

`ifdef JT51_WRSEQ_ADDRSKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= 8'd0;
      last_vld_q  <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      last_vld_q  <= last_vld_d;
    end
  end
`endif

  // Storage needs no reset: emptiness is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_jt51_wr_seq.sv
`default_nettype none
// Self-checking bench for jt51_wr_seq: strobe timing table, FIFO fill and
// overflow, busy hold-off, mid-operation reset and optional address skip.
`timescale 1ns/1ps
module tb_jt51_wr_seq;
  localparam int AW  = 2;
  localparam int PW  = 2;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [7:0]  req_data = 8'd0;
  logic        busy = 1'b0;
  logic        req_ready;
  logic [AW:0] pending;
  logic [7:0]  dout;
  logic        a0;
  logic        write;
  logic        done;
  logic        idle;

  always #5 clk = ~clk;

  jt51_wr_seq #(.AW(AW), .PW(PW), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .pending(pending),
    .dout(dout), .a0(a0), .write(write), .busy(busy), .done(done), .idle(idle)
  );

  int n_chk = 0;
  int n_err = 0;

  // Bus monitor: strobe list {a0,dout} per rising edge, strobe lengths, done count.
  logic [8:0] obs[$];
  int  len_err = 0;
  int  done_cnt = 0;
  int  wr_cycles = 0;
  int  run = 0;
  logic wr_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run     = 0;
      wr_prev = 1'b0;
    end else begin
      if (write) begin
        if (!wr_prev) obs.push_back({a0, dout});
        run++;
        wr_cycles++;
      end else if (wr_prev) begin
        if (run != PW) len_err++;
        run = 0;
      end
      if (done) done_cnt++;
      wr_prev = write;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (!idle && n < max) begin
      tick();
      n++;
    end
    chk(name, {31'd0, idle}, 32'd1);
  endtask

  typedef struct {
    string      name;
    logic       busy;
    logic       wr;
    logic       a0;
    logic [7:0] dout;
    logic       bus_chk;
    logic       done;
    logic       idle;
    logic [2:0] pend;
  } vec_t;

  vec_t vec[9];

  initial begin
    int base;
    int snap_done;
    int snap_wr;
    int bad;
    logic [7:0] ca[6];
    logic [7:0] cd[6];

    // Single command (0x20,0xC7), cycle 0 = pop cycle
    vec[0] = '{"c0", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1};
    vec[1] = '{"c1", 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[2] = '{"c2", 1'b0, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[3] = '{"c3", 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[4] = '{"c4", 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[5] = '{"c5", 1'b0, 1'b1, 1'b1, 8'hC7, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[6] = '{"c6", 1'b0, 1'b1, 1'b1, 8'hC7, 1'b1, 1'b0, 1'b0, 3'd0};
    vec[7] = '{"c7", 1'b0, 1'b0, 1'b1, 8'hC7, 1'b1, 1'b1, 1'b0, 3'd0};
    vec[8] = '{"c8", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0};

    ca = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    cd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    // Reset state
    #3;
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_a0", {31'd0, a0}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_idle", {31'd0, idle}, 32'd1);

    // Single command timing table
    base = obs.size();
    push(8'h20, 8'hC7);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      busy = vec[i].busy;
      #1;
      chk({vec[i].name, "_write"}, {31'd0, write}, {31'd0, vec[i].wr});
      chk({vec[i].name, "_done"}, {31'd0, done}, {31'd0, vec[i].done});
      chk({vec[i].name, "_idle"}, {31'd0, idle}, {31'd0, vec[i].idle});
      chk({vec[i].name, "_pending"}, {29'd0, pending}, {29'd0, vec[i].pend});
      if (vec[i].bus_chk) begin
        chk({vec[i].name, "_a0"}, {31'd0, a0}, {31'd0, vec[i].a0});
        chk({vec[i].name, "_dout"}, {24'd0, dout}, {24'd0, vec[i].dout});
      end
    end

    // Fill: five back-to-back pushes, sixth held while full, accepted on the pop
    base = obs.size();
    snap_done = done_cnt;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_addr  = ca[k];
      req_data  = cd[k];
      tick();
    end
    req_addr = ca[5];
    req_data = cd[5];
    #1;
    chk("fill_pending", {29'd0, pending}, 32'd4);
    chk("fill_ready", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("full_hold_pending", {29'd0, pending}, 32'd4);
    chk("full_hold_ready", {31'd0, req_ready}, 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("pushpop_pending", {29'd0, pending}, 32'd4);
    chk("pushpop_ready", {31'd0, req_ready}, 32'd0);
    wait_idle(200, "fill_drain_idle");
    chk("fill_pending_end", {29'd0, pending}, 32'd0);
    chk("fill_done_cnt", done_cnt - snap_done, 32'd6);
    chk("fill_strobes", obs.size() - base, 32'd12);
    for (int k = 0; k < 6; k++) begin
      if (base + 2*k + 1 < obs.size()) begin
        chk($sformatf("fill_adr%0d", k), {23'd0, obs[base + 2*k]}, {23'd0, 1'b0, ca[k]});
        chk($sformatf("fill_dat%0d", k), {23'd0, obs[base + 2*k + 1]}, {23'd0, 1'b1, cd[k]});
      end
    end

    // Busy hold-off: busy high cycles 6..69, next ADR at cycle 72
    snap_done = done_cnt;
    bad = 0;
    req_valid = 1'b1;
    req_addr  = 8'h31;
    req_data  = 8'h5A;
    tick();
    req_addr  = 8'h32;
    req_data  = 8'h6B;
    for (int c = 1; c <= 72; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      busy = (c >= 6 && c <= 69);
      #1;
      if (c >= 7 && c <= 69 && (write || done)) bad++;
      if (c == 70) begin
        chk("busy_exit_write", {31'd0, write}, 32'd0);
        chk("busy_exit_done", {31'd0, done}, 32'd1);
      end
      if (c == 71) begin
        chk("busy_pop_write", {31'd0, write}, 32'd0);
        chk("busy_pop_pending", {29'd0, pending}, 32'd1);
      end
      if (c == 72) begin
        chk("busy_next_write", {31'd0, write}, 32'd1);
        chk("busy_next_a0", {31'd0, a0}, 32'd0);
        chk("busy_next_dout", {24'd0, dout}, 32'h32);
      end
    end
    busy = 1'b0;
    chk("busy_quiet", bad, 32'd0);
    wait_idle(40, "busy_drain_idle");
    chk("busy_done_cnt", done_cnt - snap_done, 32'd2);

    // Reset during DAT with two commands queued
    push(8'h08, 8'h78);
    push(8'h11, 8'h22);
    push(8'h12, 8'h33);
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_write", {31'd0, write}, 32'd1);
    chk("pre_rst_dout", {24'd0, dout}, 32'h78);
    snap_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write", {31'd0, write}, 32'd0);
    chk("mid_rst_a0", {31'd0, a0}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_pending", {29'd0, pending}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    snap_wr = wr_cycles;
    for (int k = 0; k < 30; k++) tick();
    chk("post_rst_writes", wr_cycles - snap_wr, 32'd0);
    chk("post_rst_done", done_cnt - snap_done, 32'd0);
    chk("post_rst_idle", {31'd0, idle}, 32'd1);

`ifdef JT51_WRSEQ_ADDRSKIP_EN
    // Repeated address skips ADR/AGAP; reset forgets the tracked address
    push(8'h60, 8'h10);
    wait_idle(40, "skip_first_idle");
    base = obs.size();
    push(8'h60, 8'h11);
    tick();
    chk("skip_c1_write", {31'd0, write}, 32'd1);
    chk("skip_c1_a0", {31'd0, a0}, 32'd1);
    chk("skip_c1_dout", {24'd0, dout}, 32'h11);
    tick();
    chk("skip_c2_write", {31'd0, write}, 32'd1);
    tick();
    chk("skip_c3_done", {31'd0, done}, 32'd1);
    wait_idle(40, "skip_second_idle");
    chk("skip_strobes", obs.size() - base, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h60, 8'h55);
    tick();
    chk("skip_rst_write", {31'd0, write}, 32'd1);
    chk("skip_rst_a0", {31'd0, a0}, 32'd0);
    chk("skip_rst_dout", {24'd0, dout}, 32'h60);
    wait_idle(40, "skip_rst_idle");
`endif

    chk("strobe_len", len_err, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
